// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller for the serial pattern detector path.
//
// Holds a programmable PAT_W-bit target pattern (reset value PAT_DEFAULT, first-received bit in
// the MSB) and a CNT_W-bit match target, both loaded through a valid/ready handshake that is
// only open in IDLE. A start request arms (one cycle, clears history/fill/count) and then runs
// detection on the qualified serial stream. Each match gives a one-cycle pulse and bumps the
// wrapping match counter. A nonzero target parks the FSM in DONE once reached. A target of 0
// means the run is unlimited.
//
// Build option: define SEQ_DET_CTRL_NOOVL_EN for non-overlapping detection. History and fill
// are then cleared on every match. When it is undefined, detection overlaps.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cfg_valid/ready     configuration handshake (ready is high only in IDLE)
//   cfg_pattern/target  values latched on a handshake
//   start, abort        one-cycle run request / run cancel
//   seq_in(_valid)      serial data bit and its qualifier
//   busy, done          in ARM/RUN, in DONE
//   match_pulse         one-cycle pulse per detected match
//   match_cnt           matches in the current or last run
// All outputs are registered.
module seq_det_ctrl #(
  parameter int unsigned      PAT_W       = 5,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 5'b11011,
  parameter int unsigned      CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             seq_in,
  input  logic             seq_in_valid,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);
  localparam logic [FillW-1:0] FillThr = FillW'(PAT_W - 1);

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StArm  = 4'b0010,
    StRun  = 4'b0100,
    StDone = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  // Only the last PAT_W-1 bits are needed; the incoming bit completes the word.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [PAT_W-1:0] shifted;
  logic [CNT_W-1:0] cnt_inc;
  logic             cfg_xfer;
  logic             bit_take;
  logic             match_hit;
  logic             tgt_hit;

  assign shifted   = {hist_q, seq_in};
  assign cnt_inc   = cnt_q + 1'b1;
  assign cfg_xfer  = cfg_valid && ready_q;
  // abort outranks a same-cycle bit, so an aborted bit never shifts, pulses or counts.
  assign bit_take  = (state_q == StRun) && seq_in_valid && !abort;
  assign match_hit = bit_take && (fill_q >= FillThr) && (shifted == pat_q);
  assign tgt_hit   = (tgt_q != '0) && (cnt_inc == tgt_q);

  // State register and all datapath/output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pat_q   <= PAT_DEFAULT;
      tgt_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StArm;
      StArm:  state_d = abort ? StIdle : StRun;
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (match_hit && tgt_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (start) begin
          state_d = StArm;
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    pat_d   = pat_q;
    tgt_d   = tgt_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    if (cfg_xfer) begin
      pat_d = cfg_pattern;
      tgt_d = cfg_target;
    end

    if (state_q == StArm) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end

    if (bit_take) begin
      hist_d = shifted[PAT_W-2:0];
      fill_d = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    end

    if (match_hit) begin
      cnt_d   = cnt_inc;
      pulse_d = 1'b1;
`ifdef SEQ_DET_CTRL_NOOVL_EN
      hist_d  = '0;
      fill_d  = '0;
`endif
    end

    busy_d  = (state_d == StArm) || (state_d == StRun);
    done_d  = (state_d == StDone);
    ready_d = (state_d == StIdle);
  end

  assign cfg_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_pulse = pulse_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (PAT_W = 5, CNT_W = 4, pattern default 11011).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_seq_det_ctrl;

  localparam int unsigned PAT_W = 5;
  localparam int unsigned CNT_W = 4;
`ifdef SEQ_DET_CTRL_NOOVL_EN
  localparam bit Ovl = 1'b0;
`else
  localparam bit Ovl = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             seq_in;
  logic             seq_in_valid;
  logic             busy;
  logic             done;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  seq_det_ctrl #(
    .PAT_W      (PAT_W),
    .PAT_DEFAULT(5'b11011),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .seq_in      (seq_in),
    .seq_in_valid(seq_in_valid),
    .busy        (busy),
    .done        (done),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic v);
    seq_in       = b;
    seq_in_valid = v;
    step();
    seq_in       = 1'b0;
    seq_in_valid = 1'b0;
  endtask

  // Start from IDLE/DONE, optionally loading a new config on the same edge; ends in RUN.
  task automatic start_run(input logic do_cfg, input logic [PAT_W-1:0] pat,
                           input logic [CNT_W-1:0] tgt);
    cfg_valid   = do_cfg;
    cfg_pattern = pat;
    cfg_target  = tgt;
    start       = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_target = '0;
    start = 1'b0; abort = 1'b0; seq_in = 1'b0; seq_in_valid = 1'b0;
    step();
    step();
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (match_pulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", match_pulse); else n_pass++;
    n_checks++; if (match_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", match_cnt); else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready got=%b exp=1", cfg_ready); else n_pass++;
  endtask

  task automatic test_single_match();
    logic [4:0] s = 5'b11011;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL arm_busy got=%b exp=1", busy); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL arm_cfg_ready got=%b exp=0", cfg_ready); else n_pass++;
    step();
    for (int i = 0; i < 5; i++) begin
      send_bit(s[4-i], 1'b1);
      n_checks++;
      if (match_pulse !== (i == 4)) $display("FAIL t1_pulse bit=%0d got=%b exp=%b", i, match_pulse, (i == 4));
      else n_pass++;
    end
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t1_cnt got=%0d exp=1", match_cnt); else n_pass++;
    send_bit(1'b0, 1'b0);
    n_checks++; if (match_pulse !== 1'b0) $display("FAIL t1_pulse_drop got=%b exp=0", match_pulse); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL t1_done got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_target();
    logic [7:0] s = 8'b11011011;
    logic [4:0] p = 5'b11011;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL t2_abort_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t2_cnt_kept got=%0d exp=1", match_cnt); else n_pass++;
    start_run(1'b1, 5'b11011, 4'd2);
    n_checks++; if (match_cnt !== 4'd0) $display("FAIL t2_arm_clear got=%0d exp=0", match_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      send_bit(s[7-i], 1'b1);
      n_checks++;
      if (match_pulse !== ((i == 4) || (Ovl && i == 7)))
        $display("FAIL t2_pulse bit=%0d got=%b exp=%b", i, match_pulse, ((i == 4) || (Ovl && i == 7)));
      else n_pass++;
    end
    n_checks++; if (match_cnt !== (Ovl ? 4'd2 : 4'd1)) $display("FAIL t2_cnt got=%0d exp=%0d", match_cnt, (Ovl ? 2 : 1)); else n_pass++;
    n_checks++; if (done !== Ovl) $display("FAIL t2_done got=%b exp=%b", done, Ovl); else n_pass++;
    n_checks++; if (busy !== !Ovl) $display("FAIL t2_busy got=%b exp=%b", busy, !Ovl); else n_pass++;
`ifndef SEQ_DET_CTRL_NOOVL_EN
    // DONE ignores further bits.
    for (int i = 0; i < 5; i++) begin
      send_bit(p[4-i], 1'b1);
      n_checks++; if (match_pulse !== 1'b0) $display("FAIL t2_done_pulse bit=%0d got=%b exp=0", i, match_pulse); else n_pass++;
    end
    n_checks++; if (match_cnt !== 4'd2) $display("FAIL t2_done_cnt got=%0d exp=2", match_cnt); else n_pass++;
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL t2_idle_ready got=%b exp=1", cfg_ready); else n_pass++;
  endtask

  task automatic test_config_gap();
    logic [7:0] s = 8'b10010101;
    cfg_valid = 1'b1; cfg_pattern = 5'b10101; cfg_target = 4'd1;
    step();
    cfg_valid = 1'b0;
    start_run(1'b0, '0, '0);
    // Bit 2 is unqualified, so the valid bits are 1,0,1,0,1 by bit 5; the match lands there.
    for (int i = 0; i < 8; i++) begin
      send_bit(s[7-i], (i != 2));
      n_checks++;
      if (match_pulse !== (i == 5)) $display("FAIL t3_pulse bit=%0d got=%b exp=%b", i, match_pulse, (i == 5));
      else n_pass++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL t3_done got=%b exp=1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t3_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t3_cnt got=%0d exp=1", match_cnt); else n_pass++;
  endtask

  task automatic test_cfg_holdoff();
    logic [4:0] a = 5'b10101;
    logic [4:0] b = 5'b11011;
    abort = 1'b1;
    step();
    abort = 1'b0;
    start_run(1'b1, 5'b10101, 4'd0);
    for (int i = 0; i < 5; i++) begin
      send_bit(a[4-i], 1'b1);
      n_checks++;
      if (match_pulse !== (i == 4)) $display("FAIL t4_pulse bit=%0d got=%b exp=%b", i, match_pulse, (i == 4));
      else n_pass++;
    end
    // Offer held during RUN; 11011 must not be adopted, so streaming it gives no match.
    cfg_valid = 1'b1; cfg_pattern = 5'b11011; cfg_target = 4'd3;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL t4_ready_run got=%b exp=0", cfg_ready); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      send_bit(b[4-i], 1'b1);
      n_checks++; if (match_pulse !== 1'b0) $display("FAIL t4_held_pulse bit=%0d got=%b exp=0", i, match_pulse); else n_pass++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL t4_ready_idle got=%b exp=1", cfg_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t4_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t4_cnt_kept got=%0d exp=1", match_cnt); else n_pass++;
    step();
    cfg_valid = 1'b0;
    start_run(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      send_bit(b[4-i], 1'b1);
      n_checks++;
      if (match_pulse !== (i == 4)) $display("FAIL t4_new_pat bit=%0d got=%b exp=%b", i, match_pulse, (i == 4));
      else n_pass++;
    end
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t4_new_cnt got=%0d exp=1", match_cnt); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL t4_done got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_abort_match();
    logic [4:0] b = 5'b11011;
    for (int i = 0; i < 4; i++) begin
      send_bit(b[4-i], 1'b1);
      n_checks++; if (match_pulse !== 1'b0) $display("FAIL t5_pre_pulse bit=%0d got=%b exp=0", i, match_pulse); else n_pass++;
    end
    abort = 1'b1;
    send_bit(b[0], 1'b1);
    abort = 1'b0;
    n_checks++; if (match_pulse !== 1'b0) $display("FAIL t5_pulse got=%b exp=0", match_pulse); else n_pass++;
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t5_cnt got=%0d exp=1", match_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t5_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL t5_ready got=%b exp=1", cfg_ready); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    logic [4:0] b = 5'b11011;
    logic [2:0] r = 3'b011;
    logic [3:0] exp_cnt = 4'd0;
    logic       exp_p;
    int         per = Ovl ? 3 : 6;
    start_run(1'b1, 5'b11011, 4'd0);
    // 11011 then 15x 011: 16 overlapping matches at bits 4,7,..,49 (every 6th bit if not).
    for (int k = 0; k < 50; k++) begin
      send_bit((k < 5) ? b[4-k] : r[2-((k-5)%3)], 1'b1);
      exp_p = (k >= 4) && (((k - 4) % per) == 0);
      if (exp_p) exp_cnt = exp_cnt + 4'd1;
      n_checks++;
      if (match_pulse !== exp_p || match_cnt !== exp_cnt)
        $display("FAIL t6_wrap bit=%0d got=%b/%0d exp=%b/%0d", k, match_pulse, match_cnt, exp_p, exp_cnt);
      else n_pass++;
    end
    n_checks++; if (match_cnt !== (Ovl ? 4'd0 : 4'd8)) $display("FAIL t6_final_cnt got=%0d exp=%0d", match_cnt, (Ovl ? 0 : 8)); else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    start_run(1'b1, 5'b10101, 4'd1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    reset = 1'b1;
    send_bit(1'b0, 1'b1);
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL t6_rst_ready got=%b exp=1", cfg_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t6_rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL t6_rst_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (match_pulse !== 1'b0) $display("FAIL t6_rst_pulse got=%b exp=0", match_pulse); else n_pass++;
    n_checks++; if (match_cnt !== 4'd0) $display("FAIL t6_rst_cnt got=%0d exp=0", match_cnt); else n_pass++;
    reset = 1'b0;
    step();
    // Pattern back to 11011 and target back to 0 (unlimited, so no DONE after one match).
    start_run(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      send_bit(b[4-i], 1'b1);
      n_checks++;
      if (match_pulse !== (i == 4)) $display("FAIL t6_default_pat bit=%0d got=%b exp=%b", i, match_pulse, (i == 4));
      else n_pass++;
    end
    n_checks++; if (done !== 1'b0) $display("FAIL t6_default_tgt got=%b exp=0", done); else n_pass++;
    n_checks++; if (match_cnt !== 4'd1) $display("FAIL t6_post_cnt got=%0d exp=1", match_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_target();
    test_config_gap();
    test_cfg_holdoff();
    test_abort_match();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
